// File: rtl/mmio_ctrlr_if.sv
// Byte-serial MMIO bus between a host-side byte transport and mmio_ctrlr.
//   frame    : transaction active; low returns the controller to IDLE
//   new_data : one-cycle strobe, din holds a received byte
//   din      : received byte
//   dout     : registered response byte
interface mmio_ctrlr_if;
  logic       frame;
  logic       new_data;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output frame, output new_data, output din, input dout);
  modport slave  (input frame, input new_data, input din, output dout);
endinterface

// File: rtl/mmio_ctrlr.sv
// Byte-command MMIO controller: chip ID, switch lanes (RO), LED lanes (RW)
// and a sticky clear-on-read status register, with single and burst access.
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-low reset
//   switches : 8*IN_BYTES input lanes, lane k = bits [8k+7:8k]
//   leds     : 8*OUT_BYTES registered output lanes
//   bus      : mmio_ctrlr_if slave (frame, new_data, din, dout)
module mmio_ctrlr #(
  parameter int unsigned IN_BYTES  = 2,
  parameter int unsigned OUT_BYTES = 2,
  parameter logic [7:0]  CHIP_ID   = 8'h07
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*IN_BYTES-1:0]  switches,
  output logic [8*OUT_BYTES-1:0] leds,
  mmio_ctrlr_if.slave            bus
);

  localparam int unsigned NREG        = IN_BYTES + OUT_BYTES;
  localparam logic [3:0]  LED_FIRST   = 4'(IN_BYTES + 1);
  localparam logic [3:0]  LED_LAST    = 4'(NREG);
  localparam logic [3:0]  STATUS_ADDR = 4'hF;

  typedef enum logic [2:0] {
    IDLE, RD_ONE, WR_ONE, RD_BURST, WR_BURST
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             addr_q, addr_d;
  logic [7:0]             dout_q, dout_d;
  logic [7:0]             status_q, status_d;
  logic [8*OUT_BYTES-1:0] leds_q, leds_d;

  logic [7:0] rd_data_c;
  logic       rd_err_c;
  logic       is_led_c;
  logic       accept_c;
  logic       do_read_c;
  logic       do_write_c;
  logic       set_addr_err_c;
  logic       set_op_err_c;

  // Register file read mux at the current address; unmapped addresses read 0
  always_comb begin
    rd_data_c = 8'h00;
    rd_err_c  = 1'b1;
    if (addr_q == 4'h0) begin
      rd_data_c = CHIP_ID;
      rd_err_c  = 1'b0;
    end
    for (int k = 0; k < int'(IN_BYTES); k++) begin
      if (addr_q == 4'(k + 1)) begin
        rd_data_c = switches[8*k +: 8];
        rd_err_c  = 1'b0;
      end
    end
    for (int k = 0; k < int'(OUT_BYTES); k++) begin
      if (addr_q == 4'(int'(IN_BYTES) + 1 + k)) begin
        rd_data_c = leds_q[8*k +: 8];
        rd_err_c  = 1'b0;
      end
    end
    if (addr_q == STATUS_ADDR) begin
      rd_data_c = status_q;
      rd_err_c  = 1'b0;
    end
  end

  assign is_led_c = (addr_q >= LED_FIRST) && (addr_q <= LED_LAST);
  assign accept_c = bus.frame && bus.new_data;

  // Next-state, address sequencing and register updates
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    dout_d         = dout_q;
    leds_d         = leds_q;
    status_d       = status_q;
    do_read_c      = 1'b0;
    do_write_c     = 1'b0;
    set_addr_err_c = 1'b0;
    set_op_err_c   = 1'b0;

    if (!bus.frame) begin
      state_d = IDLE;
      addr_d  = 4'h0;
    end else if (accept_c) begin
      unique case (state_q)
        IDLE: begin
          addr_d = bus.din[3:0];
          dout_d = 8'h00;
          unique case (bus.din[7:4])
            4'h0:    state_d = RD_ONE;
            4'hF:    state_d = WR_ONE;
            4'h8:    state_d = RD_BURST;
            4'hE:    state_d = WR_BURST;
            default: set_op_err_c = 1'b1;
          endcase
        end
        RD_ONE: begin
          do_read_c = 1'b1;
          state_d   = IDLE;
        end
        WR_ONE: begin
          do_write_c = 1'b1;
          state_d    = IDLE;
        end
        RD_BURST: begin
          do_read_c = 1'b1;
          // Reads sweep the whole map; 0xF wraps to 0 by 4-bit overflow
          addr_d    = (addr_q == LED_LAST) ? 4'h0 : addr_q + 4'd1;
        end
        WR_BURST: begin
          do_write_c = 1'b1;
          // Writes circulate over the LED window only
          addr_d     = (addr_q == LED_LAST) ? LED_FIRST : addr_q + 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_read_c) begin
      dout_d         = rd_data_c;
      set_addr_err_c = rd_err_c;
      if (addr_q == STATUS_ADDR) status_d = 8'h00;
    end

    if (do_write_c) begin
      dout_d = 8'h00;
      if (is_led_c) begin
        for (int k = 0; k < int'(OUT_BYTES); k++) begin
          if (addr_q == 4'(int'(IN_BYTES) + 1 + k)) leds_d[8*k +: 8] = bus.din;
        end
      end else begin
        set_addr_err_c = 1'b1;
      end
    end

    // Set after the read-clear so a same-edge error event survives
    if (set_addr_err_c) status_d[0] = 1'b1;
    if (set_op_err_c)   status_d[1] = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= 4'h0;
      dout_q   <= 8'h00;
      status_q <= 8'h00;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      status_q <= status_d;
      leds_q   <= leds_d;
    end
  end

  assign leds     = leds_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_mmio_ctrlr.sv
// Self-checking bench for mmio_ctrlr (IN_BYTES=2, OUT_BYTES=2, CHIP_ID=0x07).
module tb_mmio_ctrlr;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switches;
  logic [15:0] leds;

  mmio_ctrlr_if bus();

  mmio_ctrlr #(
    .IN_BYTES (2),
    .OUT_BYTES(2),
    .CHIP_ID  (8'h07)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .switches(switches),
    .leds    (leds),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    bit          chk_leds;
    logic [15:0] exp_leds;
    bit          end_frame;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         vec_count  = 0;
  int         miss_count = 0;
  logic [7:0] last_dout  = 8'h00;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic [7:0] e, input bit cl,
                     input logic [15:0] el, input bit ef);
    vec_t v;
    v.din = d; v.exp_dout = e; v.chk_leds = cl; v.exp_leds = el; v.end_frame = ef;
    vecs.push_back(v);
  endtask

  // Drive one accepted byte; expectation queued at drive, checked one cycle later
  task automatic send(input logic [7:0] d, input logic [7:0] e, input string name);
    logic [7:0] x;
    @(negedge clk);
    bus.frame    = 1'b1;
    bus.new_data = 1'b1;
    bus.din      = d;
    exp_q.push_back(e);
    @(negedge clk);
    bus.new_data = 1'b0;
    bus.din      = 8'h00;
    x = exp_q.pop_front();
    check(name, {8'h00, bus.dout}, {8'h00, x});
    last_dout = x;
  endtask

  // Hold frame low for n edges; dout must not move
  task automatic frame_drop(input int n, input string name);
    @(negedge clk);
    bus.frame = 1'b0;
    repeat (n) @(negedge clk);
    bus.frame = 1'b1;
    check(name, {8'h00, bus.dout}, {8'h00, last_dout});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.frame    = 1'b1;
    bus.new_data = 1'b0;
    bus.din      = 8'h00;
    switches     = 16'h00FF;
    #1;
    check("reset_dout", {8'h00, bus.dout}, 16'h0000);
    check("reset_leds", leds, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Chip ID, twice
    add(8'h00, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h07, 0, 16'h0, 0);
    add(8'h00, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h07, 0, 16'h0, 0);
    // Switch reads, LED writes and read-back
    add(8'h01, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'hFF, 0, 16'h0, 0);
    add(8'h02, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h00, 0, 16'h0, 0);
    add(8'hF3, 8'h00, 0, 16'h0, 0); add(8'hFF, 8'h00, 1, 16'h00FF, 0);
    add(8'hF4, 8'h00, 0, 16'h0, 0); add(8'hAA, 8'h00, 1, 16'hAAFF, 0);
    add(8'h03, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'hFF, 0, 16'h0, 0);
    add(8'h04, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'hAA, 0, 16'h0, 0);
    // Burst write wrapping over LED lanes, then full-map burst read with wrap
    add(8'hE3, 8'h00, 0, 16'h0, 0); add(8'h11, 8'h00, 1, 16'hAA11, 0);
    add(8'h22, 8'h00, 1, 16'h2211, 0); add(8'h33, 8'h00, 1, 16'h2233, 1);
    add(8'h80, 8'h00, 0, 16'h0, 0);
    add(8'h5A, 8'h07, 0, 16'h0, 0); add(8'h5A, 8'hFF, 0, 16'h0, 0);
    add(8'h5A, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h33, 0, 16'h0, 0);
    add(8'h5A, 8'h22, 0, 16'h0, 0); add(8'h5A, 8'h07, 0, 16'h0, 1);
    // Address error, status clear-on-read, opcode error
    add(8'h05, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h00, 0, 16'h0, 0);
    add(8'h0F, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h01, 0, 16'h0, 0);
    add(8'h0F, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h00, 0, 16'h0, 0);
    add(8'h35, 8'h00, 0, 16'h0, 0);
    add(8'h0F, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h02, 0, 16'h0, 0);
    // Write to a non-LED address is discarded and flags an address error
    add(8'hF1, 8'h00, 0, 16'h0, 0); add(8'h77, 8'h00, 1, 16'h2233, 0);
    add(8'h0F, 8'h00, 0, 16'h0, 0); add(8'h5A, 8'h01, 0, 16'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].din, vecs[i].exp_dout, $sformatf("vec%0d_dout", i));
      if (vecs[i].chk_leds) check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
      if (vecs[i].end_frame) frame_drop(1, $sformatf("vec%0d_hold", i));
    end

    // Switches are sampled on the accepting edge
    @(negedge clk);
    switches = 16'hA55A;
    send(8'h01, 8'h00, "sw_cmd0"); send(8'h00, 8'h5A, "sw_lane0");
    send(8'h02, 8'h00, "sw_cmd1"); send(8'h00, 8'hA5, "sw_lane1");

    // Frame abort of a write burst; new_data with frame low is ignored
    send(8'hE3, 8'h00, "abort_cmd"); send(8'hAA, 8'h00, "abort_wr");
    @(negedge clk);
    bus.frame = 1'b0;
    @(negedge clk);
    bus.new_data = 1'b1;
    bus.din      = 8'h0F;
    @(negedge clk);
    bus.new_data = 1'b0;
    bus.frame    = 1'b1;
    check("abort_hold", {8'h00, bus.dout}, 16'h0000);
    send(8'h03, 8'h00, "abort_rd_cmd"); send(8'h5A, 8'hAA, "abort_rd");
    check("abort_leds", leds, 16'h22AA);

    // Asynchronous reset mid write burst
    send(8'hE3, 8'h00, "rstw_cmd"); send(8'h55, 8'h00, "rstw_wr");
    check("rstw_leds_pre", leds, 16'h2255);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstw_leds", leds, 16'h0000);
    check("rstw_dout", {8'h00, bus.dout}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    send(8'h00, 8'h00, "rstw_id_cmd"); send(8'h5A, 8'h07, "rstw_id");

    // Asynchronous reset mid read burst with nonzero dout
    send(8'h80, 8'h00, "rstr_cmd"); send(8'h5A, 8'h07, "rstr_rd");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstr_dout", {8'h00, bus.dout}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    send(8'h00, 8'h00, "rstr_first_cmd"); send(8'h5A, 8'h07, "rstr_id");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
